operand_forward_unit: RTL and testbench
=======================================

OPERAND_FORWARD_UNIT -- requirements
Module: operand_forward_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, data path width.
REQ-002 SHALL have ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous reset, active-low.
- id_valid  in  1  ID stage holds a real instruction.
- id_opcode  in  7  opcode of the ID instruction.
- id_rd  in  5  destination register of the ID instruction.
- id_rs1  in  5  first source register of the ID instruction.
- id_rs2  in  5  second source register of the ID instruction.
- id_rs1_data  in  XLEN  register-file read of rs1.
- id_rs2_data  in  XLEN  register-file read of rs2.
- ex_fwd_data  in  XLEN  forwardable result of the EX instruction.
- mem_fwd_data  in  XLEN  forwardable result of the MEM instruction, including load data.
- wb_fwd_data  in  XLEN  value being written back in WB.
- flush  in  1  branch or jump redirect; kills the ID and EX instructions.
- op1  out  XLEN  resolved rs1 operand.
- op2  out  XLEN  resolved rs2 operand.
- op1_sel  out  2  rs1 source: 0 regfile, 1 EX, 2 MEM, 3 WB.
- op2_sel  out  2  rs2 source, same encoding as op1_sel.
- stall  out  1  hold PC and IF/ID; insert a bubble into EX.

Function
REQ-003 SHALL keep a three-entry tracker (EX, MEM, WB) per slot: valid, rd[4:0], wr (writes rd), ld (is load).
REQ-004 wr SHALL be 1 for opcodes 0110111 LUI, 0010111 AUIPC, 1101111 JAL, 1100111 JALR, 0000011 LOAD, 0010011 OP-IMM, 0110011 OP; 0 for 1100011 BRANCH, 0100011 STORE, and any other opcode.
REQ-005 ld SHALL be 1 only for opcode 0000011.
REQ-006 rs1 SHALL count as used for JALR, LOAD, OP-IMM, BRANCH, STORE, OP; rs2 SHALL count as used for BRANCH, STORE, OP; LUI, AUIPC and JAL use neither.
REQ-007 A slot SHALL match rsN when valid & wr & rd==rsN & rsN!=0.
REQ-008 Operand selection SHALL be combinational with priority EX > MEM > WB > regfile; for an unused source or rsN==0, opN_sel=0 and opN=idN_data.
REQ-009 stall SHALL be asserted combinationally when id_valid & !flush & the EX slot is a load that matches a used source.
REQ-010 Each rising edge with no stall and no flush: EX <= decoded ID instruction (valid=id_valid), MEM <= EX, WB <= MEM.
REQ-011 On a stall edge: EX <= invalid bubble, MEM <= EX, WB <= MEM; ID inputs are held externally.
REQ-012 On the following cycle the load sits in MEM; that cycle SHALL forward mem_fwd_data (sel=2) and deassert stall.
REQ-013 On a flush edge: EX <= invalid, MEM <= EX, WB <= MEM.
REQ-014 flush SHALL override stall; stall is 0 while flush is 1.
REQ-015 When several slots hold the same rd, the youngest (EX first) SHALL win.
REQ-016 An instruction with id_rd=0 SHALL never be forwarded, even when its opcode has wr=1.
REQ-017 Latency: op outputs reflect tracker state within the same cycle; the tracker updates one cycle after ID.

Reset
REQ-018 rst_n=0 SHALL asynchronously clear all tracker valid bits.
REQ-019 While all valid bits are clear, stall=0, op1_sel=op2_sel=0, op1=id_rs1_data, op2=id_rs2_data.
REQ-020 Reset asserted mid-stall SHALL drop stall immediately.
REQ-021 After reset release, the first rising edge SHALL load the ID instruction normally.

Verification
REQ-022 Bench SHALL cover the following directed scenarios:
- EX-ALU: ADDI x3 in EX, ex_fwd_data=0x11; OP rs1=3 -> op1=0x11, op1_sel=1, stall=0.
- Load-use: LOAD x5 in EX; OP rs2=5 -> stall=1 for one cycle. Next cycle mem_fwd_data=0xAB -> op2=0xAB, op2_sel=2, stall=0.
- Priority: x7 written in EX (0x1), MEM (0x2) and WB (0x3); ADD rs1=rs2=7 -> op1=op2=0x1, sel=1.
- Non-writers and x0: STORE in EX, or ADDI with rd=0 in EX; dependent rs -> sel=0, regfile data.
- Flush: LOAD x5 in EX with flush=1; dependent OP -> stall=0. Next edge EX is invalid and no forward is taken from it.
- Reset mid-stall: stall=1, pulse rst_n=0 -> stall=0 and sel=0 immediately.

Source files
------------

// File: rtl/operand_forward_unit_if.sv
// ID-stage operand-forwarding bus: instruction fields and bypass values in,
// resolved operands, source selects and load-use stall out.
interface operand_forward_unit_if #(
  parameter int XLEN = 32
);
  logic            id_valid;
  logic [6:0]      id_opcode;
  logic [4:0]      id_rd;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [XLEN-1:0] ex_fwd_data;
  logic [XLEN-1:0] mem_fwd_data;
  logic [XLEN-1:0] wb_fwd_data;
  logic            flush;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic [1:0]      op1_sel;
  logic [1:0]      op2_sel;
  logic            stall;

  modport master (
    output id_valid, id_opcode, id_rd, id_rs1, id_rs2, id_rs1_data, id_rs2_data,
           ex_fwd_data, mem_fwd_data, wb_fwd_data, flush,
    input  op1, op2, op1_sel, op2_sel, stall
  );

  modport slave (
    input  id_valid, id_opcode, id_rd, id_rs1, id_rs2, id_rs1_data, id_rs2_data,
           ex_fwd_data, mem_fwd_data, wb_fwd_data, flush,
    output op1, op2, op1_sel, op2_sel, stall
  );
endinterface

// File: rtl/operand_forward_unit.sv
// Tracks the destination registers of the EX/MEM/WB instructions and resolves
// ID source operands from the youngest producer, stalling on load-use hazards.
module operand_forward_unit #(
  parameter int XLEN = 32
) (
  input logic                  clk,
  input logic                  rst_n,
  operand_forward_unit_if.slave bus
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
  } slot_t;

  slot_t ex_slot, mem_slot, wb_slot;
  logic  id_wr, id_ld, rs1_used, rs2_used;
  logic [1:0] sel1, sel2;

  always_comb begin
    id_wr    = 1'b0;
    id_ld    = 1'b0;
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    case (bus.id_opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL: id_wr = 1'b1;
      OPC_JALR, OPC_OPIMM: begin
        id_wr    = 1'b1;
        rs1_used = 1'b1;
      end
      OPC_LOAD: begin
        id_wr    = 1'b1;
        id_ld    = 1'b1;
        rs1_used = 1'b1;
      end
      OPC_OP: begin
        id_wr    = 1'b1;
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      OPC_BRANCH, OPC_STORE: begin
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      default: ;
    endcase
  end

  function automatic logic hit(input slot_t s, input logic [4:0] rs);
    return s.valid & s.wr & (s.rd == rs) & (rs != '0);
  endfunction

  // Youngest producer first: EX, then MEM, then WB, else register file.
  function automatic logic [1:0] pick(input logic used, input logic [4:0] rs,
                                      input slot_t e, input slot_t m, input slot_t w);
    if (!used)        return 2'd0;
    else if (hit(e, rs)) return 2'd1;
    else if (hit(m, rs)) return 2'd2;
    else if (hit(w, rs)) return 2'd3;
    else              return 2'd0;
  endfunction

  always_comb begin
    sel1 = pick(rs1_used, bus.id_rs1, ex_slot, mem_slot, wb_slot);
    sel2 = pick(rs2_used, bus.id_rs2, ex_slot, mem_slot, wb_slot);
    case (sel1)
      2'd1:    bus.op1 = bus.ex_fwd_data;
      2'd2:    bus.op1 = bus.mem_fwd_data;
      2'd3:    bus.op1 = bus.wb_fwd_data;
      default: bus.op1 = bus.id_rs1_data;
    endcase
    case (sel2)
      2'd1:    bus.op2 = bus.ex_fwd_data;
      2'd2:    bus.op2 = bus.mem_fwd_data;
      2'd3:    bus.op2 = bus.wb_fwd_data;
      default: bus.op2 = bus.id_rs2_data;
    endcase
    bus.op1_sel = sel1;
    bus.op2_sel = sel2;
    // A select of 1 already means "used source matches a valid EX writer".
    bus.stall = bus.id_valid & ~bus.flush & ex_slot.ld &
                ((sel1 == 2'd1) | (sel2 == 2'd1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_slot  <= '0;
      mem_slot <= '0;
      wb_slot  <= '0;
    end else begin
      if (bus.stall || bus.flush) ex_slot <= '0;
      else ex_slot <= '{valid: bus.id_valid, rd: bus.id_rd, wr: id_wr, ld: id_ld};
      mem_slot <= ex_slot;
      wb_slot  <= mem_slot;
    end
  end

endmodule

// File: tb/tb_operand_forward_unit.sv
// Directed bench for operand_forward_unit: stimulus pushes hand-computed
// expectations into a queue; a monitor pops and compares them.
module tb_operand_forward_unit;
  localparam int XLEN = 32;
  localparam logic [6:0] LUI = 7'b0110111, LOAD = 7'b0000011, OPIMM = 7'b0010011,
                         OP = 7'b0110011, STORE = 7'b0100011;
  localparam logic [31:0] R1 = 32'hA1A1A1A1, R2 = 32'hB2B2B2B2,
                          EXD = 32'h11, MEMD = 32'h22, WBD = 32'h33;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  operand_forward_unit_if #(.XLEN(XLEN)) bus ();
  operand_forward_unit #(.XLEN(XLEN)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic [7:0]  id;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [1:0]  s1;
    logic [1:0]  s2;
    logic        stall;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [7:0] vec_id = '0;

  initial begin
    forever begin
      @(negedge clk or negedge rst_n);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        n_tests++;
        if (bus.op1 !== e.op1 || bus.op2 !== e.op2 || bus.op1_sel !== e.s1 ||
            bus.op2_sel !== e.s2 || bus.stall !== e.stall) begin
          n_fail++;
          $display("FAIL vec%0d: got op1=%h op2=%h sel1=%0d sel2=%0d stall=%b, want op1=%h op2=%h sel1=%0d sel2=%0d stall=%b",
                   e.id, bus.op1, bus.op2, bus.op1_sel, bus.op2_sel, bus.stall,
                   e.op1, e.op2, e.s1, e.s2, e.stall);
        end
      end
    end
  end

  task automatic setd(input logic [31:0] e, input logic [31:0] m, input logic [31:0] w);
    bus.ex_fwd_data  = e;
    bus.mem_fwd_data = m;
    bus.wb_fwd_data  = w;
  endtask

  task automatic expect_now(input logic [31:0] o1, input logic [31:0] o2,
                            input logic [1:0] s1, input logic [1:0] s2, input logic st);
    exp_q.push_back('{id: vec_id, op1: o1, op2: o2, s1: s1, s2: s2, stall: st});
    vec_id++;
  endtask

  task automatic drive(input logic v, input logic [6:0] opc, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic fl,
                       input logic [31:0] o1, input logic [31:0] o2,
                       input logic [1:0] s1, input logic [1:0] s2, input logic st);
    @(posedge clk);
    #1;
    bus.id_valid  = v;
    bus.id_opcode = opc;
    bus.id_rd     = rd;
    bus.id_rs1    = rs1;
    bus.id_rs2    = rs2;
    bus.flush     = fl;
    setd(EXD, MEMD, WBD);
    expect_now(o1, o2, s1, s2, st);
  endtask

  initial begin
    bus.id_rs1_data = R1;
    bus.id_rs2_data = R2;
    bus.flush = 1'b0;
    bus.id_valid = 1'b0;
    bus.id_opcode = '0;
    bus.id_rd = '0;
    bus.id_rs1 = '0;
    bus.id_rs2 = '0;
    setd(EXD, MEMD, WBD);

    // Reset held: empty tracker, regfile operands.
    drive(1, OP, 5'd1, 5'd3, 5'd4, 0, R1, R2, 0, 0, 0);
    @(negedge clk); #2 rst_n = 1'b1;

    drive(1, OPIMM, 5'd3, 5'd0, 5'd0, 0, R1, R2, 0, 0, 0);  // ADDI x3
    drive(1, OP, 5'd8, 5'd3, 5'd9, 0, EXD, R2, 1, 0, 0);    // EX-ALU forward
    drive(1, OP, 5'd10, 5'd8, 5'd3, 0, EXD, MEMD, 1, 2, 0);
    drive(1, OP, 5'd0, 5'd3, 5'd0, 0, WBD, R2, 3, 0, 0);    // WB forward, rs2=x0
    drive(1, OP, 5'd11, 5'd0, 5'd0, 0, R1, R2, 0, 0, 0);    // rd=0 writer in EX
    drive(1, STORE, 5'd12, 5'd11, 5'd10, 0, EXD, WBD, 1, 3, 0);
    drive(1, OP, 5'd7, 5'd12, 5'd11, 0, R1, MEMD, 0, 2, 0); // STORE in EX not forwarded
    drive(1, OPIMM, 5'd7, 5'd7, 5'd7, 0, EXD, R2, 1, 0, 0); // rs2 unused
    drive(1, LUI, 5'd7, 5'd7, 5'd7, 0, R1, R2, 0, 0, 0);    // neither used
    // x7 in EX, MEM and WB: youngest wins.
    drive(1, OP, 5'd13, 5'd7, 5'd7, 0, 32'h1, 32'h1, 1, 1, 0);
    setd(32'h1, 32'h2, 32'h3);
    drive(1, OP, 5'd14, 5'd7, 5'd7, 0, 32'h2, 32'h2, 2, 2, 0);
    setd(32'h1, 32'h2, 32'h3);
    // Load-use.
    drive(1, LOAD, 5'd5, 5'd14, 5'd0, 0, EXD, R2, 1, 0, 0);
    drive(1, OP, 5'd15, 5'd1, 5'd5, 0, R1, EXD, 0, 1, 1);
    drive(1, OP, 5'd15, 5'd1, 5'd5, 0, R1, 32'hAB, 0, 2, 0);
    setd(EXD, 32'hAB, WBD);
    drive(1, OP, 5'd16, 5'd5, 5'd15, 0, WBD, EXD, 3, 1, 0);
    // Flush over a load-use.
    drive(1, LOAD, 5'd5, 5'd0, 5'd0, 0, R1, R2, 0, 0, 0);
    drive(1, OP, 5'd17, 5'd5, 5'd16, 1, EXD, MEMD, 1, 2, 0);
    drive(1, OP, 5'd18, 5'd5, 5'd16, 0, MEMD, WBD, 2, 3, 0);
    // Invalid ID never stalls and never enters the tracker as valid.
    drive(1, LOAD, 5'd20, 5'd0, 5'd0, 0, R1, R2, 0, 0, 0);
    drive(0, OP, 5'd21, 5'd20, 5'd0, 0, EXD, R2, 1, 0, 0);
    drive(1, OP, 5'd22, 5'd21, 5'd18, 0, R1, WBD, 0, 3, 0);
    // Reset mid-stall.
    drive(1, LOAD, 5'd6, 5'd0, 5'd0, 0, R1, R2, 0, 0, 0);
    drive(1, OP, 5'd23, 5'd6, 5'd22, 0, EXD, MEMD, 1, 2, 1);
    @(negedge clk); #2;
    expect_now(R1, R2, 0, 0, 0);
    rst_n = 1'b0;
    @(posedge clk); #3 rst_n = 1'b1;
    // First edge after release loads ID normally.
    bus.id_opcode = OPIMM; bus.id_rd = 5'd24; bus.id_rs1 = 5'd0; bus.id_rs2 = 5'd0;
    drive(1, OP, 5'd25, 5'd24, 5'd6, 0, EXD, R2, 1, 0, 0);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    #2;
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
